// File: rtl/com_csr_apb2csr_mux.sv
// com_csr_apb2csr_mux: APB4 slave bridging to NUM_CH CSR master channels selected by base/size address windows.
// Latency: a zero-wait hit completes in 2 APB cycles (setup + access); back-to-back transfers need no idle cycle.
// Backpressure: PREADY follows the selected csr_ready; a decode miss, a secure violation or a ready timeout completes early with PSLVERR.
//
// Ports:
//   PCLK, PRESET                  clock, asynchronous active-high reset
//   PADDR/PPROT/PSELx/PENABLE/PWRITE/PWDATA/PSTRB  APB request (only PPROT[1], non-secure, is used)
//   PREADY/PRDATA/PSLVERR         APB response; all zero outside the access phase
//   csr_valid (one-hot), csr_write, csr_addr (window-relative), csr_wdata, csr_wstrb   CSR request
//   csr_ready, csr_rdata          per-channel CSR response, ch0 in the LSBs
//   err_pulse                     one-cycle pulses: [0] decode miss, [1] timeout, [2] secure violation
module com_csr_apb2csr_mux #(
    parameter int                       NUM_CH     = 2,
    parameter int                       AW_APB     = 32,
    parameter int                       DW_APB     = 32,
    parameter int                       AW_CSR     = 16,
    parameter logic [NUM_CH*AW_APB-1:0] RGN_BASE   = {32'h2000, 32'h1000},
    parameter logic [NUM_CH*AW_APB-1:0] RGN_SIZE   = {32'h1000, 32'h0100},
    parameter logic [NUM_CH-1:0]        RGN_SECURE = 2'b00,
    parameter int                       TIMEOUT    = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [AW_APB-1:0]        PADDR,
    input  logic [2:0]               PPROT,
    input  logic                     PSELx,
    input  logic                     PENABLE,
    input  logic                     PWRITE,
    input  logic [DW_APB-1:0]        PWDATA,
    input  logic [DW_APB/8-1:0]      PSTRB,
    output logic                     PREADY,
    output logic [DW_APB-1:0]        PRDATA,
    output logic                     PSLVERR,
    output logic [NUM_CH-1:0]        csr_valid,
    output logic                     csr_write,
    output logic [AW_CSR-1:0]        csr_addr,
    output logic [DW_APB-1:0]        csr_wdata,
    output logic [DW_APB/8-1:0]      csr_wstrb,
    input  logic [NUM_CH-1:0]        csr_ready,
    input  logic [NUM_CH*DW_APB-1:0] csr_rdata,
    output logic [2:0]               err_pulse
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    // SETUP covers both the first access-phase cycle after a setup phase and a
    // setup phase that directly follows a completed transfer; ACCESS covers wait states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_SETUP  = 3'b010,
        ST_ACCESS = 3'b100
    } state_e;

    state_e              state_q, state_d;
    logic                write_q, write_d;
    logic                nonsec_q, nonsec_d;
    logic                hit_q, hit_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [AW_CSR-1:0]   addr_q, addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                dec_hit;
    logic [IW-1:0]       dec_idx;
    logic [AW_CSR-1:0]   dec_addr;

    logic                setup_cyc;
    logic                acc_act;
    logic                sec_viol;
    logic                err_cls;
    logic                rdy_sel;
    logic                tmo_hit;

    logic                unused_pprot;
    assign unused_pprot = PPROT[0] ^ PPROT[2];

    // Window compare is done one bit wider than the bus so BASE+SIZE cannot wrap.
    function automatic logic in_rgn(input logic [AW_APB-1:0] a,
                                    input logic [AW_APB-1:0] base,
                                    input logic [AW_APB-1:0] size);
        logic [AW_APB:0] a_x, lo_x, hi_x;
        a_x  = {1'b0, a};
        lo_x = {1'b0, base};
        hi_x = {1'b0, base} + {1'b0, size};
        return (a_x >= lo_x) && (a_x < hi_x);
    endfunction

    // Scan from the highest index down so the lowest matching window wins on overlap.
    always_comb begin
        dec_hit  = 1'b0;
        dec_idx  = '0;
        dec_addr = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (in_rgn(PADDR, RGN_BASE[i*AW_APB +: AW_APB], RGN_SIZE[i*AW_APB +: AW_APB])) begin
                dec_hit  = 1'b1;
                dec_idx  = IW'(i);
                dec_addr = AW_CSR'(PADDR - RGN_BASE[i*AW_APB +: AW_APB]);
            end
        end
    end

    assign setup_cyc = PSELx && !PENABLE;
    assign acc_act   = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) && PSELx && PENABLE;
    assign sec_viol  = hit_q && nonsec_q && RGN_SECURE[idx_q];
    assign err_cls   = !hit_q || sec_viol;
    assign rdy_sel   = csr_ready[idx_q];
    assign tmo_hit   = (TIMEOUT != 0) && (cnt_q == TMO_LAST) && !rdy_sel;

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        nonsec_d  = nonsec_q;
        hit_d     = hit_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        PRDATA    = '0;
        csr_valid = '0;
        err_pulse = 3'b000;

        // Response for the current access-phase cycle.
        if (acc_act) begin
            if (err_cls) begin
                PREADY    = 1'b1;
                PSLVERR   = 1'b1;
                err_pulse = !hit_q ? 3'b001 : 3'b100;
            end else begin
                csr_valid[idx_q] = 1'b1;
                if (rdy_sel) begin
                    PREADY = 1'b1;
                    if (!write_q) begin
                        PRDATA = csr_rdata[idx_q*DW_APB +: DW_APB];
                    end
                end else if (tmo_hit) begin
                    PREADY    = 1'b1;
                    PSLVERR   = 1'b1;
                    err_pulse = 3'b010;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Every setup phase latches the request and restarts the timeout.
        if (setup_cyc) begin
            write_d  = PWRITE;
            nonsec_d = PPROT[1];
            hit_d    = dec_hit;
            idx_d    = dec_idx;
            addr_d   = dec_addr;
            cnt_d    = '0;
        end

        case (state_q)
            ST_IDLE: begin
                if (setup_cyc) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (!PSELx)             state_d = ST_IDLE;
                else if (acc_act)       state_d = PREADY ? ST_SETUP : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!PSELx)             state_d = ST_IDLE;
                else if (setup_cyc)     state_d = ST_SETUP;
                else if (PREADY)        state_d = ST_SETUP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= ST_IDLE;
            write_q  <= 1'b0;
            nonsec_q <= 1'b0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            nonsec_q <= nonsec_d;
            hit_q    <= hit_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign csr_write = write_q;
    assign csr_addr  = addr_q;
    assign csr_wdata = PWDATA;
    assign csr_wstrb = write_q ? PSTRB : '0;

endmodule
